// File: rtl/bias_weight_lane_updater.sv
// Layer parameter store with a lane-multiplexed saturating SGD update (w -= lr*d*y, b -= lr*d).
// LANES columns are updated per cycle; the full {weight, bias} image is published after each update or load.
module bias_weight_lane_updater #(
  parameter int NP    = 4,
  parameter int NC    = 4,
  parameter int WF    = 16,
  parameter int FRAC  = 12,
  parameter int LANES = 1
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iMode,
  input  logic [WF-1:0]               iLR,
  input  logic                        iValid_AS_State,
  output logic                        oReady_AS_State,
  input  logic [NP*WF-1:0]            iData_AS_State,
  input  logic                        iValid_AS_Delta,
  output logic                        oReady_AS_Delta,
  input  logic [NC*WF-1:0]            iData_AS_Delta,
  input  logic                        iValid_AS_Load,
  output logic                        oReady_AS_Load,
  input  logic [NP*NC*WF+NC*WF-1:0]   iData_AS_Load,
  output logic                        oValid_BM_WeightBias,
  input  logic                        iReady_BM_WeightBias,
  output logic [NP*NC*WF+NC*WF-1:0]   oData_BM_WeightBias
);

  localparam int P   = NC / LANES;
  localparam int CW  = (P > 1) ? $clog2(P) : 1;
  localparam int NCI = (NC > 1) ? $clog2(NC) : 1;
  localparam logic signed [WF-1:0] SMAX = {1'b0, {(WF-1){1'b1}}};
  localparam logic signed [WF-1:0] SMIN = {1'b1, {(WF-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_PUBLISH} state_t;

  state_t r_state, w_next;

  logic signed [WF-1:0] r_w  [NP][NC];
  logic signed [WF-1:0] r_b  [NC];
  logic signed [WF-1:0] r_y  [NP];
  logic signed [WF-1:0] r_d  [NC];
  logic signed [WF-1:0] r_lr;
  logic [CW-1:0]        r_c;

  logic [NCI-1:0]       w_col  [LANES];
  logic signed [WF-1:0] w_ad   [LANES];
  logic signed [WF-1:0] w_bnew [LANES];
  logic signed [WF-1:0] w_wnew [NP][LANES];
  logic                 w_load_fire, w_train_fire, w_last;

  // Q-format multiply: full-width product, floor shift, clamp back to WF bits.
  function automatic logic signed [WF-1:0] mul_q(input logic signed [WF-1:0] a,
                                                 input logic signed [WF-1:0] b);
    logic signed [2*WF-1:0] p;
    p = (2*WF)'(a) * (2*WF)'(b);
    p = p >>> FRAC;
    if (p[2*WF-1:WF-1] == '0 || p[2*WF-1:WF-1] == '1) return p[WF-1:0];
    return p[2*WF-1] ? SMIN : SMAX;
  endfunction

  function automatic logic signed [WF-1:0] sub_sat(input logic signed [WF-1:0] a,
                                                   input logic signed [WF-1:0] b);
    logic signed [WF:0] d;
    d = {a[WF-1], a} - {b[WF-1], b};
    if (d[WF] == d[WF-1]) return d[WF-1:0];
    return d[WF] ? SMIN : SMAX;
  endfunction

  assign w_last       = (r_c == CW'(P - 1));
  assign w_load_fire  = oReady_AS_Load & iValid_AS_Load;
  assign w_train_fire = oReady_AS_State & iValid_AS_State;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    oReady_AS_Load       = 1'b0;
    oReady_AS_State      = 1'b0;
    oReady_AS_Delta      = 1'b0;
    oValid_BM_WeightBias = 1'b0;
    case (r_state)
      S_IDLE: begin
        oReady_AS_Load       = 1'b1;
        oReady_AS_State      = iMode & ~iValid_AS_Load & iValid_AS_Delta;
        oReady_AS_Delta      = iMode & ~iValid_AS_Load & iValid_AS_State;
        oValid_BM_WeightBias = ~iMode;
        if (iValid_AS_Load)                                      w_next = S_PUBLISH;
        else if (iMode && iValid_AS_State && iValid_AS_Delta)    w_next = S_UPDATE;
      end
      S_UPDATE:  if (w_last) w_next = S_PUBLISH;
      S_PUBLISH: begin
        oValid_BM_WeightBias = 1'b1;
        if (iReady_BM_WeightBias) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
    // State is already IDLE during reset, so the handshake outputs are masked explicitly.
    if (!iRST) begin
      oReady_AS_Load       = 1'b0;
      oReady_AS_State      = 1'b0;
      oReady_AS_Delta      = 1'b0;
      oValid_BM_WeightBias = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_col[l]  = NCI'(32'(r_c) * LANES + l);
      w_ad[l]   = mul_q(r_lr, r_d[w_col[l]]);
      w_bnew[l] = sub_sat(r_b[w_col[l]], w_ad[l]);
      for (int unsigned i = 0; i < NP; i++)
        w_wnew[i][l] = sub_sat(r_w[i][w_col[l]], mul_q(r_y[i], w_ad[l]));
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int unsigned j = 0; j < NC; j++) begin
        r_b[j] <= '0;
        r_d[j] <= '0;
        for (int unsigned i = 0; i < NP; i++) r_w[i][j] <= '0;
      end
      for (int unsigned i = 0; i < NP; i++) r_y[i] <= '0;
      r_lr <= '0;
      r_c  <= '0;
    end else begin
      if (w_load_fire) begin
        for (int unsigned j = 0; j < NC; j++) begin
          r_b[j] <= iData_AS_Load[j*WF +: WF];
          for (int unsigned i = 0; i < NP; i++)
            r_w[i][j] <= iData_AS_Load[NC*WF + (i*NC + j)*WF +: WF];
        end
      end else if (w_train_fire) begin
        for (int unsigned i = 0; i < NP; i++) r_y[i] <= iData_AS_State[i*WF +: WF];
        for (int unsigned j = 0; j < NC; j++) r_d[j] <= iData_AS_Delta[j*WF +: WF];
        r_lr <= iLR;
        r_c  <= '0;
      end
      if (r_state == S_UPDATE) begin
        r_c <= r_c + CW'(1);
        for (int unsigned l = 0; l < LANES; l++) begin
          r_b[w_col[l]] <= w_bnew[l];
          for (int unsigned i = 0; i < NP; i++) r_w[i][w_col[l]] <= w_wnew[i][l];
        end
      end
    end
  end

  always_comb begin
    oData_BM_WeightBias = '0;
    for (int unsigned j = 0; j < NC; j++) begin
      oData_BM_WeightBias[j*WF +: WF] = r_b[j];
      for (int unsigned i = 0; i < NP; i++)
        oData_BM_WeightBias[NC*WF + (i*NC + j)*WF +: WF] = r_w[i][j];
    end
  end

endmodule

// File: tb/tb_bias_weight_lane_updater.sv
// Scoreboard bench for bias_weight_lane_updater (NP=2, NC=4, WF=8, FRAC=4, LANES=2).
// Expected images come from an integer reference model and are queued when stimulus is driven.
module tb_bias_weight_lane_updater;

  localparam int NP = 2, NC = 4, WF = 8, FRAC = 4, LANES = 2;
  localparam int IW = NP*NC*WF + NC*WF;

  logic            iCLK, iRST, iMode;
  logic [WF-1:0]   iLR;
  logic            iValid_AS_State, oReady_AS_State;
  logic [NP*WF-1:0] iData_AS_State;
  logic            iValid_AS_Delta, oReady_AS_Delta;
  logic [NC*WF-1:0] iData_AS_Delta;
  logic            iValid_AS_Load, oReady_AS_Load;
  logic [IW-1:0]   iData_AS_Load;
  logic            oValid_BM_WeightBias, iReady_BM_WeightBias;
  logic [IW-1:0]   oData_BM_WeightBias;

  int mw [NP][NC];
  int mb [NC];
  logic [IW-1:0] sb_q[$];
  logic [IW-1:0] last_out;
  int total, bad;

  bias_weight_lane_updater #(.NP(NP), .NC(NC), .WF(WF), .FRAC(FRAC), .LANES(LANES)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode), .iLR(iLR),
    .iValid_AS_State(iValid_AS_State), .oReady_AS_State(oReady_AS_State), .iData_AS_State(iData_AS_State),
    .iValid_AS_Delta(iValid_AS_Delta), .oReady_AS_Delta(oReady_AS_Delta), .iData_AS_Delta(iData_AS_Delta),
    .iValid_AS_Load(iValid_AS_Load), .oReady_AS_Load(oReady_AS_Load), .iData_AS_Load(iData_AS_Load),
    .oValid_BM_WeightBias(oValid_BM_WeightBias), .iReady_BM_WeightBias(iReady_BM_WeightBias),
    .oData_BM_WeightBias(oData_BM_WeightBias)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic int clampi(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic logic [IW-1:0] model_img();
    logic [IW-1:0] img;
    img = '0;
    for (int j = 0; j < NC; j++) begin
      img[j*WF +: WF] = WF'(mb[j]);
      for (int i = 0; i < NP; i++) img[NC*WF + (i*NC + j)*WF +: WF] = WF'(mw[i][j]);
    end
    return img;
  endfunction

  task automatic model_train(input int y[NP], input int d[NC], input int lr);
    int ad;
    for (int j = 0; j < NC; j++) begin
      ad = clampi((lr * d[j]) >>> FRAC);
      mb[j] = clampi(mb[j] - ad);
      for (int i = 0; i < NP; i++) mw[i][j] = clampi(mw[i][j] - clampi((y[i] * ad) >>> FRAC));
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < NC; j++) begin
      mb[j] = 0;
      for (int i = 0; i < NP; i++) mw[i][j] = 0;
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_train(input int y[NP], input int d[NC], input int lr);
    for (int i = 0; i < NP; i++) iData_AS_State[i*WF +: WF] = WF'(y[i]);
    for (int j = 0; j < NC; j++) iData_AS_Delta[j*WF +: WF] = WF'(d[j]);
    iLR = WF'(lr);
    iValid_AS_State = 1'b1;
    iValid_AS_Delta = 1'b1;
  endtask

  task automatic send_load(input string name);
    int k;
    logic [IW-1:0] img;
    img = model_img();
    sb_q.push_back(img);
    iData_AS_Load  = img;
    iValid_AS_Load = 1'b1;
    #1;
    k = 0;
    while (!oReady_AS_Load && k < 20) begin tick(); k++; end
    total++;
    if (oReady_AS_Load !== 1'b1) begin
      bad++;
      $display("FAIL %s_load_hs: oReady_AS_Load=%b after %0d cycles, want 1", name, oReady_AS_Load, k);
    end
    tick();
    iValid_AS_Load = 1'b0;
  endtask

  task automatic send_train(input int y[NP], input int d[NC], input int lr, input string name);
    int k;
    model_train(y, d, lr);
    sb_q.push_back(model_img());
    drive_train(y, d, lr);
    #1;
    k = 0;
    while (!(oReady_AS_State && oReady_AS_Delta) && k < 20) begin tick(); k++; end
    total++;
    if (!(oReady_AS_State === 1'b1 && oReady_AS_Delta === 1'b1)) begin
      bad++;
      $display("FAIL %s_train_hs: readies=%b%b after %0d cycles, want 11", name, oReady_AS_State, oReady_AS_Delta, k);
    end
    tick();
    iValid_AS_State = 1'b0;
    iValid_AS_Delta = 1'b0;
  endtask

  task automatic recv_out(input string name);
    int k;
    logic [IW-1:0] exp;
    k = 0;
    while (!oValid_BM_WeightBias && k < 20) begin tick(); k++; end
    total++;
    if (oValid_BM_WeightBias !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid: oValid=%b after %0d cycles, want 1", name, oValid_BM_WeightBias, k);
    end else begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL %s_data: got %h, want nothing (scoreboard empty)", name, oData_BM_WeightBias);
      end else begin
        exp = sb_q.pop_front();
        if (oData_BM_WeightBias !== exp) begin
          bad++;
          $display("FAIL %s_data: got %h, want %h", name, oData_BM_WeightBias, exp);
        end
      end
      last_out = oData_BM_WeightBias;
      iReady_BM_WeightBias = 1'b1;
      tick();
      iReady_BM_WeightBias = 1'b0;
    end
  endtask

  task automatic test_reset();
    iValid_AS_State = 1'b1; iValid_AS_Delta = 1'b1; iValid_AS_Load = 1'b1;
    repeat (3) tick();
    total += 4;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", oValid_BM_WeightBias); end
    if (oReady_AS_Load !== 1'b0)  begin bad++; $display("FAIL rst_rdy_load: got %b want 0", oReady_AS_Load); end
    if (oReady_AS_State !== 1'b0) begin bad++; $display("FAIL rst_rdy_state: got %b want 0", oReady_AS_State); end
    if (oReady_AS_Delta !== 1'b0) begin bad++; $display("FAIL rst_rdy_delta: got %b want 0", oReady_AS_Delta); end
    iValid_AS_State = 1'b0; iValid_AS_Delta = 1'b0; iValid_AS_Load = 1'b0;
    iRST = 1'b1;
    #1;
    total += 3;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL rel_valid: got %b want 0", oValid_BM_WeightBias); end
    if (oData_BM_WeightBias !== '0) begin bad++; $display("FAIL rel_data: got %h want 0", oData_BM_WeightBias); end
    if (oReady_AS_Load !== 1'b1) begin bad++; $display("FAIL rel_rdy_load: got %b want 1", oReady_AS_Load); end
    iMode = 1'b0;
    tick();
    total++;
    if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL rel_test_valid: got %b want 1", oValid_BM_WeightBias); end
    iMode = 1'b1;
    tick();
  endtask

  task automatic test_load_train();
    int y[NP];
    int d[NC];
    for (int j = 0; j < NC; j++) begin
      mb[j] = 0;
      for (int i = 0; i < NP; i++) mw[i][j] = 16;
    end
    send_load("lt");
    recv_out("lt_load");
    y = '{16, 32};
    d = '{16, 16, 16, 16};
    send_train(y, d, 16, "lt");
    total += 2;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL lt_lat_upd0: oValid=%b want 0", oValid_BM_WeightBias); end
    tick();
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL lt_lat_upd1: oValid=%b want 0", oValid_BM_WeightBias); end
    tick();
    total++;
    if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL lt_lat_pub: oValid=%b want 1", oValid_BM_WeightBias); end
    recv_out("lt_train");
    total += 3;
    if (last_out[NC*WF + 3*WF +: WF] !== 8'h00) begin bad++; $display("FAIL lt_w03: got %h want 00", last_out[NC*WF + 3*WF +: WF]); end
    if (last_out[NC*WF + (NC+2)*WF +: WF] !== 8'hF0) begin bad++; $display("FAIL lt_w12: got %h want f0", last_out[NC*WF + (NC+2)*WF +: WF]); end
    if (last_out[1*WF +: WF] !== 8'hF0) begin bad++; $display("FAIL lt_b1: got %h want f0", last_out[1*WF +: WF]); end
  endtask

  task automatic test_saturation();
    int y[NP];
    int d[NC];
    for (int j = 0; j < NC; j++) begin
      mb[j] = 127;
      for (int i = 0; i < NP; i++) mw[i][j] = -128;
    end
    send_load("sat");
    recv_out("sat_load");
    y = '{16, 16};
    d = '{16, 16, 16, 16};
    send_train(y, d, 16, "sat1");
    recv_out("sat1");
    total++;
    if (last_out[NC*WF + (NC+1)*WF +: WF] !== 8'h80) begin bad++; $display("FAIL sat_w_low: got %h want 80", last_out[NC*WF + (NC+1)*WF +: WF]); end
    d = '{-128, -128, -128, -128};
    send_train(y, d, 16, "sat2");
    recv_out("sat2");
    total++;
    if (last_out[2*WF +: WF] !== 8'h7F) begin bad++; $display("FAIL sat_b_high: got %h want 7f", last_out[2*WF +: WF]); end
  endtask

  task automatic test_backpressure();
    int y[NP];
    int d[NC];
    int k, hs;
    logic [IW-1:0] snap, exp;
    y = '{20, -12};
    d = '{5, -40, 100, -3};
    send_train(y, d, 24, "bp");
    k = 0;
    while (!oValid_BM_WeightBias && k < 20) begin tick(); k++; end
    total += 2;
    if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", oValid_BM_WeightBias); end
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : ~oData_BM_WeightBias;
    if (oData_BM_WeightBias !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", oData_BM_WeightBias, exp); end
    snap = exp;
    drive_train(y, d, 24);
    for (int c = 0; c < 10; c++) begin
      tick();
      total += 3;
      if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", c, oValid_BM_WeightBias); end
      if (oData_BM_WeightBias !== snap) begin bad++; $display("FAIL bp_hold_data: cycle %0d got %h want %h", c, oData_BM_WeightBias, snap); end
      if (oReady_AS_State !== 1'b0 || oReady_AS_Delta !== 1'b0) begin
        bad++; $display("FAIL bp_hold_rdy: cycle %0d got %b%b want 00", c, oReady_AS_State, oReady_AS_Delta);
      end
    end
    iValid_AS_State = 1'b0; iValid_AS_Delta = 1'b0;
    iReady_BM_WeightBias = 1'b1;
    hs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (oValid_BM_WeightBias) hs++;
      tick();
    end
    iReady_BM_WeightBias = 1'b0;
    total++;
    if (hs != 1) begin bad++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
  endtask

  task automatic test_test_mode();
    int y[NP];
    int d[NC];
    logic [IW-1:0] exp;
    y = '{64, 64};
    d = '{64, 64, 64, 64};
    exp = model_img();
    iMode = 1'b0;
    drive_train(y, d, 64);
    for (int c = 0; c < 20; c++) begin
      iReady_BM_WeightBias = c[0];
      #1;
      total += 3;
      if (oReady_AS_State !== 1'b0 || oReady_AS_Delta !== 1'b0) begin
        bad++; $display("FAIL tm_rdy: cycle %0d got %b%b want 00", c, oReady_AS_State, oReady_AS_Delta);
      end
      if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL tm_valid: cycle %0d got %b want 1", c, oValid_BM_WeightBias); end
      if (oData_BM_WeightBias !== exp) begin bad++; $display("FAIL tm_data: cycle %0d got %h want %h", c, oData_BM_WeightBias, exp); end
      tick();
    end
    iValid_AS_State = 1'b0; iValid_AS_Delta = 1'b0;
    iReady_BM_WeightBias = 1'b0;
    iMode = 1'b1;
    #1;
    total++;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL tm_exit_valid: got %b want 0", oValid_BM_WeightBias); end
    tick();
  endtask

  task automatic test_load_priority();
    int y[NP];
    int d[NC];
    logic [IW-1:0] img;
    for (int j = 0; j < NC; j++) begin
      mb[j] = j * 10 - 15;
      for (int i = 0; i < NP; i++) mw[i][j] = 7 * (i + 1) - j * 9;
    end
    img = model_img();
    sb_q.push_back(img);
    y = '{-48, 33};
    d = '{17, -90, 2, 60};
    model_train(y, d, 40);
    sb_q.push_back(model_img());
    iData_AS_Load = img;
    iValid_AS_Load = 1'b1;
    drive_train(y, d, 40);
    #1;
    total += 3;
    if (oReady_AS_Load !== 1'b1)  begin bad++; $display("FAIL pr_rdy_load: got %b want 1", oReady_AS_Load); end
    if (oReady_AS_State !== 1'b0) begin bad++; $display("FAIL pr_rdy_state: got %b want 0", oReady_AS_State); end
    if (oReady_AS_Delta !== 1'b0) begin bad++; $display("FAIL pr_rdy_delta: got %b want 0", oReady_AS_Delta); end
    tick();
    iValid_AS_Load = 1'b0;
    #1;
    total += 2;
    if (oValid_BM_WeightBias !== 1'b1) begin bad++; $display("FAIL pr_pub_valid: got %b want 1", oValid_BM_WeightBias); end
    if (oReady_AS_State !== 1'b0 || oReady_AS_Delta !== 1'b0) begin
      bad++; $display("FAIL pr_pub_rdy: got %b%b want 00", oReady_AS_State, oReady_AS_Delta);
    end
    recv_out("pr_load");
    #1;
    total++;
    if (oReady_AS_State !== 1'b1 || oReady_AS_Delta !== 1'b1) begin
      bad++; $display("FAIL pr_idle_rdy: got %b%b want 11", oReady_AS_State, oReady_AS_Delta);
    end
    tick();
    iValid_AS_State = 1'b0; iValid_AS_Delta = 1'b0;
    recv_out("pr_train");
  endtask

  task automatic test_random();
    int y[NP];
    int d[NC];
    int lr;
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < NC; j++) begin
        mb[j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NP; i++) mw[i][j] = int'($urandom_range(0, 255)) - 128;
      end
      send_load("rnd");
      recv_out("rnd_load");
      for (int i = 0; i < NP; i++) y[i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < NC; j++) d[j] = int'($urandom_range(0, 255)) - 128;
      lr = int'($urandom_range(0, 255)) - 128;
      send_train(y, d, lr, "rnd");
      recv_out("rnd_train");
    end
  endtask

  task automatic test_mid_reset();
    int y[NP];
    int d[NC];
    y = '{30, -30};
    d = '{50, 50, -50, -50};
    send_train(y, d, 32, "mr");
    iRST = 1'b0;
    iValid_AS_State = 1'b1; iValid_AS_Delta = 1'b1; iValid_AS_Load = 1'b1;
    #1;
    total += 3;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b want 0", oValid_BM_WeightBias); end
    if (oData_BM_WeightBias !== '0) begin bad++; $display("FAIL mr_data: got %h want 0", oData_BM_WeightBias); end
    if (oReady_AS_Load !== 1'b0 || oReady_AS_State !== 1'b0 || oReady_AS_Delta !== 1'b0) begin
      bad++; $display("FAIL mr_rdy: got %b%b%b want 000", oReady_AS_Load, oReady_AS_State, oReady_AS_Delta);
    end
    model_clear();
    sb_q.delete();
    repeat (2) tick();
    iValid_AS_State = 1'b0; iValid_AS_Delta = 1'b0; iValid_AS_Load = 1'b0;
    iRST = 1'b1;
    #1;
    total += 2;
    if (oValid_BM_WeightBias !== 1'b0) begin bad++; $display("FAIL mr_rel_valid: got %b want 0", oValid_BM_WeightBias); end
    if (oReady_AS_Load !== 1'b1) begin bad++; $display("FAIL mr_rel_idle: oReady_AS_Load=%b want 1", oReady_AS_Load); end
    tick();
    send_train(y, d, 32, "mr_post");
    recv_out("mr_post");
  endtask

  initial begin
    total = 0; bad = 0;
    iRST = 1'b0; iMode = 1'b1; iLR = '0;
    iValid_AS_State = 1'b0; iData_AS_State = '0;
    iValid_AS_Delta = 1'b0; iData_AS_Delta = '0;
    iValid_AS_Load = 1'b0;  iData_AS_Load = '0;
    iReady_BM_WeightBias = 1'b0;
    last_out = '0;
    model_clear();
    test_reset();
    test_load_train();
    test_saturation();
    test_backpressure();
    test_test_mode();
    test_load_priority();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bias_weight_lane_updater.md
# bias_weight_lane_updater

Parametrised successor to the fully parallel bias/weight update block. It stores the NP×NC weight matrix and the NC bias vector of one layer. A TRAIN update applies w -= (lr·δ)·y and b -= lr·δ with saturating fixed-point arithmetic. The update is time-multiplexed over LANES output columns per cycle, so area scales with LANES instead of NP·NC. It sits between the backward-pass delta producer and the forward-pass neuron array, and adds a parameter-load port and an explicit TEST mode that publishes continuously.

## Interface
- NP, 4: number of predecessor neurons (rows).
- NC, 4: number of current-layer neurons (columns).
- WF, 16: word width, signed two's complement.
- FRAC, 12: fractional bits of every word and of iLR.
- LANES, 1: columns processed per update cycle. Must divide NC. P = NC/LANES.
- iCLK  in  1  clock.
- iRST  in  1  reset. Asynchronous, active-low. Deasserts synchronously in the bench.
- iMode  in  1  1 = TRAIN, 0 = TEST. Sampled only in IDLE.
- iLR  in  WF  learning rate. Sampled at the input handshake.
- iValid_AS_State / oReady_AS_State / iData_AS_State  in/out/in  1/1/NP*WF  activations y; y_i is at [i*WF +: WF].
- iValid_AS_Delta / oReady_AS_Delta / iData_AS_Delta  in/out/in  1/1/NC*WF  deltas δ; δ_j is at [j*WF +: WF].
- iValid_AS_Load / oReady_AS_Load / iData_AS_Load  in/out/in  1/1/NP*NC*WF+NC*WF  parameter image, same layout as the output.
- oValid_BM_WeightBias / iReady_BM_WeightBias / oData_BM_WeightBias  out/in/out  1/1/NP*NC*WF+NC*WF  {weight, bias}. b_j is at [j*WF +: WF]; w_ij is at [NC*WF + (i*NC+j)*WF +: WF].

## Operation
- FSM states: IDLE, UPDATE, PUBLISH.
- IDLE, TRAIN:
  - oReady_AS_State = iValid_AS_Delta and oReady_AS_Delta = iValid_AS_State, i.e. a joined handshake.
  - On a joined handshake, capture y, δ and iLR, clear column counter c, and go to UPDATE.
- IDLE, load:
  - oReady_AS_Load = 1 in IDLE in either mode.
  - Load has priority: while iValid_AS_Load = 1, the State/Delta readies are 0.
  - On a load handshake, write the whole image and go to PUBLISH.
- IDLE, TEST:
  - State/Delta readies are 0.
  - oValid_BM_WeightBias = 1 with the current parameters, and no state change on the output handshake.
- UPDATE, one cycle per column group, for columns j = c*LANES .. c*LANES+LANES-1:
  - ad_j = sat(ashr(iLR·δ_j, FRAC)).
  - b_j <= sat(b_j − ad_j).
  - For every i: w_ij <= sat(w_ij − sat(ashr(y_i·ad_j, FRAC))).
  - c increments each cycle. When c = P−1, go to PUBLISH.
- PUBLISH:
  - oValid_BM_WeightBias = 1 and data is held stable.
  - On iReady_BM_WeightBias, go to IDLE.
- Arithmetic rules:
  - Products are full 2·WF signed.
  - ashr is an arithmetic right shift (floor).
  - sat clamps to [−2^(WF−1), 2^(WF−1)−1].
  - Subtraction is computed in WF+1 bits, then clamped.
- A mode change during UPDATE or PUBLISH takes effect only on return to IDLE. A started update always completes.
- Reset at any time, including mid-UPDATE:
  - Weights, biases and the counter go to 0; state goes to IDLE.
  - oValid = 0 and all readies are 0 while iRST = 0.

## Timing
- Reset values:
  - oValid_BM_WeightBias = 0 in TRAIN.
  - oValid_BM_WeightBias follows TEST-mode IDLE behaviour (1) one cycle after reset release if iMode = 0.
  - All oReady_AS_* = 0 during reset.
- Latency:
  - Input handshake at edge T.
  - UPDATE occupies edges T+1 .. T+P.
  - oValid_BM_WeightBias = 1 from the cycle following edge T+P. With LANES = NC that is the cycle after T+1.
- Load latency: oValid_BM_WeightBias = 1 in the cycle after the load edge.
- Throughput: one update per P+2 cycles at best. Output backpressure stalls the FSM in PUBLISH indefinitely with no data change.
- Readies are combinational from state and from the peer valid. Valid never depends on ready.

## Test plan
Bench configuration for all scenarios: NP=2, NC=4, WF=8, FRAC=4, LANES=2.
- Load, then train:
  - Stimulus: load all w=16, b=0; TRAIN; iLR=16; y=(16,32); δ=(16,16,16,16).
  - Response: after 2 UPDATE cycles, output w_0j=0, w_1j=−16, b_j=−16.
- Saturation:
  - Stimulus: load w=−128, b=127; iLR=16; y=(16,16); δ=(16,…) then δ=(−128,…).
  - Response: first update gives w=−128 (clamped low). Second update gives b=127 (clamped high).
- Backpressure:
  - Stimulus: hold iReady_BM_WeightBias=0 for 10 cycles after oValid rises.
  - Response: data stable, State/Delta readies stay 0, exactly one output handshake when ready is released.
- TEST mode:
  - Stimulus: iMode=0 with State/Delta valid for 20 cycles.
  - Response: no input handshake, parameters unchanged, oValid constantly 1.
- Mid-update reset:
  - Stimulus: assert iRST=0 in the first UPDATE cycle.
  - Response: output image all zero, oValid=0 immediately (asynchronous), state IDLE after release.
- Load priority:
  - Stimulus: assert Load, State and Delta valid in the same IDLE cycle.
  - Response: only the load handshakes, then PUBLISH; the training pair is accepted after return to IDLE.
